// File: rtl/ila_capture_pkg.sv
// Shared definitions for the ILA sample-capture block and the host-readout logic.
package ila_capture_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 25;
    localparam int DEFAULT_DEPTH        = 256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_READ = 3'd4
    } state_e;

    // States in which the sample bus is written into the buffer.
    function automatic logic is_capture_state(input state_e st);
        return (st == ST_FILL) || (st == ST_WAIT) || (st == ST_POST);
    endfunction

endpackage

// File: rtl/ila_capture_ram.sv
// Simple dual-port buffer: synchronous write, registered read, single clock.
// No reset on the array or read register so it maps onto GateMate block RAM.
module ila_capture_ram #(
    parameter  int WIDTH  = 25,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port: one sample per enabled cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: output register holds its value while rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ila_sample_capture.sv
// Captures a trigger-centred window of the DUT sample bus into a circular
// buffer and streams it out oldest-first over a ready/valid port.
module ila_sample_capture
    import ila_capture_pkg::*;
#(
    parameter  int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter  int DEPTH        = DEFAULT_DEPTH,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    ILA_rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [ADDR_W-1:0]       pre_trig,
    input  logic [SAMPLE_WIDTH-1:0] trig_value,
    input  logic [SAMPLE_WIDTH-1:0] trig_mask,
    output logic                    armed,
    output logic                    triggered,
    output logic [ADDR_W-1:0]       trig_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic                    rd_last
);

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]       pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0]       post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0]       pre_trig_q, pre_trig_d;
    logic [SAMPLE_WIDTH-1:0] trig_value_q, trig_value_d;
    logic [SAMPLE_WIDTH-1:0] trig_mask_q, trig_mask_d;
    logic [ADDR_W-1:0]       trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0]       start_addr_q, start_addr_d;
    // One extra bit so the index can reach DEPTH, meaning "all words fetched".
    logic [ADDR_W:0]         fetch_idx_q, fetch_idx_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_last_q, rd_last_d;
    logic                    triggered_q, triggered_d;

    logic                    mem_we;
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_rd_addr;
    logic [SAMPLE_WIDTH-1:0] mem_rd_data;
    logic                    trig_match;

    ila_capture_ram #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_q),
        .wr_data (sample_in),
        .rd_en   (mem_rd_en),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // Next-state, counter and read-prefetch logic; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        pre_trig_d   = pre_trig_q;
        trig_value_d = trig_value_q;
        trig_mask_d  = trig_mask_q;
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        fetch_idx_d  = fetch_idx_q;
        rd_valid_d   = rd_valid_q;
        rd_last_d    = rd_last_q;
        triggered_d  = triggered_q;
        mem_we       = 1'b0;
        mem_rd_en    = 1'b0;
        mem_rd_addr  = start_addr_q + fetch_idx_q[ADDR_W-1:0];
        trig_match   = (((sample_in ^ trig_value_q) & trig_mask_q) == '0);

        if (is_capture_state(state_q)) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    pre_trig_d   = pre_trig;
                    trig_value_d = trig_value;
                    trig_mask_d  = trig_mask;
                    pre_cnt_d    = '0;
                    fetch_idx_d  = '0;
                    state_d      = (pre_trig == '0) ? ST_WAIT : ST_FILL;
                end
            end
            ST_FILL: begin
                pre_cnt_d = pre_cnt_q + ADDR_W'(1);
                if (pre_cnt_q == pre_trig_q - ADDR_W'(1)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (trig_match) begin
                    trig_addr_d  = wr_ptr_q;
                    start_addr_d = wr_ptr_q - pre_trig_q;
                    triggered_d  = 1'b1;
                    post_cnt_d   = ~pre_trig_q;
                    state_d      = (pre_trig_q == '1) ? ST_READ : ST_POST;
                end
            end
            ST_POST: begin
                post_cnt_d = post_cnt_q - ADDR_W'(1);
                if (post_cnt_q == ADDR_W'(1)) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (!fetch_idx_q[ADDR_W] && (!rd_valid_q || rd_ready)) begin
                    mem_rd_en   = 1'b1;
                    fetch_idx_d = fetch_idx_q + (ADDR_W+1)'(1);
                    rd_valid_d  = 1'b1;
                    rd_last_d   = (fetch_idx_q[ADDR_W-1:0] == '1);
                end else if (rd_valid_q && rd_ready) begin
                    rd_valid_d  = 1'b0;
                    rd_last_d   = 1'b0;
                    triggered_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
            triggered_d = 1'b0;
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge ILA_rst) begin
        if (!ILA_rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            pre_trig_q   <= '0;
            trig_value_q <= '0;
            trig_mask_q  <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            fetch_idx_q  <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            triggered_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            pre_trig_q   <= pre_trig_d;
            trig_value_q <= trig_value_d;
            trig_mask_q  <= trig_mask_d;
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            fetch_idx_q  <= fetch_idx_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            triggered_q  <= triggered_d;
        end
    end

    // The RAM read register has no reset, so gate it to keep the port at zero when idle.
    assign rd_data   = rd_valid_q ? mem_rd_data : '0;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign armed     = is_capture_state(state_q);
    assign triggered = triggered_q;
    assign trig_addr = trig_addr_q;

endmodule
